// File: rtl/common_enums_pkg.sv
// Shared enumerations for the chess clock controller and its neighbours.
// PAUSED exists only when CHESS_PAUSE_EN is defined.
package common_enums;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARMED,
        RUN_W,
        RUN_B,
`ifdef CHESS_PAUSE_EN
        PAUSED,
`endif
        TIMEOUT
    } clock_ctrl_state_t;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } player_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_q <= 1'b0;
            rise  <= 1'b0;
        end else begin
            din_q <= din;
            rise  <= din & ~din_q;
        end
    end

endmodule

// File: rtl/chess_clock_ctrl.sv
// Chess clock sequencer: drives load/enable of two countdown timers and tracks turn/moves.
// Optional pause support is compiled in with `define CHESS_PAUSE_EN.
module chess_clock_ctrl
    import common_enums::*;
#(
    parameter int MOVE_W       = 9,
    parameter int START_PLAYER = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              new_game,
    input  logic [1:0]        mode_in,
    input  logic              move_done,
    input  logic              pause_btn,
    input  logic              time_up_w,
    input  logic              time_up_b,
    output logic              load,
    output logic              start,
    output logic              count_w,
    output logic              count_b,
    output logic [1:0]        mode_sel,
    output logic              turn,
    output logic              game_over,
    output logic              winner,
    output logic [MOVE_W-1:0] moves
);

    localparam player_t FIRST = (START_PLAYER != 0) ? BLACK : WHITE;

    clock_ctrl_state_t state;
    logic              new_game_p0;
    logic              move_done_p0;
    logic              pause_p0;

    function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rise_detect u_new_game_rise (.clk(clk), .reset_n(reset_n), .din(new_game),  .rise(new_game_p0));
    rise_detect u_move_rise     (.clk(clk), .reset_n(reset_n), .din(move_done), .rise(move_done_p0));

`ifdef CHESS_PAUSE_EN
    clock_ctrl_state_t saved_state;
    rise_detect u_pause_rise    (.clk(clk), .reset_n(reset_n), .din(pause_btn), .rise(pause_p0));
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
    assign pause_p0     = 1'b0;
`endif

    // Edge pulses above -> registered state and outputs below
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            load      <= 1'b0;
            start     <= 1'b0;
            count_w   <= 1'b0;
            count_b   <= 1'b0;
            mode_sel  <= 2'd0;
            turn      <= FIRST;
            game_over <= 1'b0;
            winner    <= 1'b0;
            moves     <= '0;
`ifdef CHESS_PAUSE_EN
            saved_state <= RUN_W;
`endif
        end else begin
            load <= 1'b0;
            if (new_game_p0) begin
                state     <= LOAD;
                load      <= 1'b1;
                mode_sel  <= mode_in;
                moves     <= '0;
                start     <= 1'b0;
                count_w   <= 1'b0;
                count_b   <= 1'b0;
                turn      <= FIRST;
                game_over <= 1'b0;
                winner    <= 1'b0;
            end else begin
                case (state)
                    LOAD: state <= ARMED;
                    ARMED: begin
                        // The opening move only starts the clock; it is not counted.
                        if (move_done_p0) begin
                            start <= 1'b1;
                            if (FIRST == WHITE) begin
                                state   <= RUN_W;
                                count_w <= 1'b1;
                            end else begin
                                state   <= RUN_B;
                                count_b <= 1'b1;
                            end
                        end
                    end
                    RUN_W: begin
                        if (time_up_w) begin
                            state     <= TIMEOUT;
                            game_over <= 1'b1;
                            winner    <= BLACK;
                            count_w   <= 1'b0;
                            count_b   <= 1'b0;
                        end else if (move_done_p0) begin
                            state   <= RUN_B;
                            count_w <= 1'b0;
                            count_b <= 1'b1;
                            turn    <= BLACK;
                            moves   <= sat_inc(moves);
`ifdef CHESS_PAUSE_EN
                        end else if (pause_p0) begin
                            state       <= PAUSED;
                            saved_state <= RUN_W;
                            count_w     <= 1'b0;
`endif
                        end
                    end
                    RUN_B: begin
                        if (time_up_b) begin
                            state     <= TIMEOUT;
                            game_over <= 1'b1;
                            winner    <= WHITE;
                            count_w   <= 1'b0;
                            count_b   <= 1'b0;
                        end else if (move_done_p0) begin
                            state   <= RUN_W;
                            count_b <= 1'b0;
                            count_w <= 1'b1;
                            turn    <= WHITE;
                            moves   <= sat_inc(moves);
`ifdef CHESS_PAUSE_EN
                        end else if (pause_p0) begin
                            state       <= PAUSED;
                            saved_state <= RUN_B;
                            count_b     <= 1'b0;
`endif
                        end
                    end
`ifdef CHESS_PAUSE_EN
                    PAUSED: begin
                        if (pause_p0) begin
                            state   <= saved_state;
                            count_w <= (saved_state == RUN_W);
                            count_b <= (saved_state == RUN_B);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/chess_clock_ctrl.md
CHESS_CLOCK_CTRL -- requirements
Module: chess_clock_ctrl

Interface
REQ-001 Parameter MOVE_W, default 9: width of move counter.
REQ-002 Parameter START_PLAYER, default 0: side to move first (0 = white, 1 = black).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 new_game  input  1  level; a rising edge requests a game (re)initialisation.
REQ-006 mode_in  input  2  time-control selection, sampled only on new_game rising edge.
REQ-007 move_done  input  1  level from move logic; a rising edge means the side to move has committed a legal move.
REQ-008 pause_btn  input  1  level, pre-debounced; a rising edge toggles pause (only if PAUSE_EN).
REQ-009 time_up_w, time_up_b  input  1 each  expiry flags from the white and black countdown instances.
REQ-010 load  output  1  one-cycle pulse to both countdown instances.
REQ-011 start  output  1  level; held high from first run state onward.
REQ-012 count_w, count_b  output  1 each  level enables for the white and black countdown instances.
REQ-013 mode_sel  output  2  registered copy of mode_in, driven to both countdown instances.
REQ-014 turn  output  1  side to move (0 = white, 1 = black).
REQ-015 game_over  output  1  high in TIMEOUT.
REQ-016 winner  output  1  valid when game_over; side whose opponent flagged.
REQ-017 moves  output  MOVE_W  count of completed half-moves.

Function
REQ-018 FSM states: IDLE, LOAD, ARMED, RUN_W, RUN_B, PAUSED, TIMEOUT.
REQ-019 All inputs with "rising edge" semantics are edge-detected internally; a level held high produces exactly one event.
REQ-020 A new_game edge from any state: latch mode_in into mode_sel, clear moves, enter LOAD.
REQ-021 LOAD lasts exactly 1 cycle, asserts load, then goes to ARMED.
REQ-022 ARMED: count_w = count_b = 0. The first move_done edge sets start = 1 and enters RUN_W or RUN_B per START_PLAYER. That first edge does not toggle turn or increment moves.
REQ-023 RUN_W: count_w = 1, count_b = 0, turn = 0. A move_done edge goes to RUN_B on the next cycle, toggles turn and increments moves. RUN_B behaves symmetrically.
REQ-024 count_w and count_b are never high simultaneously; the enable switches with zero dead cycles.
REQ-025 time_up of the side to move, seen in a RUN state, goes to TIMEOUT: game_over = 1, winner = other side, both counts = 0.
REQ-026 Simultaneous time_up and move_done edge in the same cycle: time_up wins and the move is discarded.
REQ-027 time_up of the side not to move is ignored.
REQ-028 TIMEOUT is exited only by new_game; move_done and pause_btn are ignored there.
REQ-029 moves saturates at 2^MOVE_W-1 and does not wrap.
REQ-030 IDLE exits only on new_game. Before that, start = 0 and both counts = 0.
REQ-031 All outputs are registered. Each outputs reflects a state change one cycle after the triggering edge is detected.

Reset
REQ-032 reset_n low asynchronously forces: state IDLE, load 0, start 0, count_w 0, count_b 0, mode_sel 0, turn = START_PLAYER, game_over 0, winner 0, moves 0, edge-detect history 0.
REQ-033 Reset mid-game discards all state; there is no resume.

Configuration
REQ-034 Macro CHESS_PAUSE_EN.
- Defined: a pause_btn edge in RUN_W/RUN_B enters PAUSED with both counts 0 and the previous run state saved. A pause_btn edge in PAUSED returns to the saved state. move_done is ignored in PAUSED.
- Undefined: pause_btn is unused, the PAUSED state is absent, and a RUN state exits only via move_done, time_up or new_game.

Structure
REQ-035 The state enum clock_ctrl_state_t and player_t (WHITE = 0, BLACK = 1) belong in the shared common_enums package.
REQ-036 The sub-module rise_detect (1-bit registered rising-edge pulse, async active-low reset) is instantiated once per edge-sensed input.

Verification
REQ-037 Reset, then new_game edge with mode_in = 2 -> load high exactly 1 cycle, mode_sel = 2, state ARMED, count_w = count_b = 0.
REQ-038 From ARMED, 3 move_done edges -> RUN_W, then RUN_B (moves = 1, turn = 1), then RUN_W (moves = 2, turn = 0). count_w/count_b are never both high.
REQ-039 In RUN_B, time_up_b = 1 in the same cycle as a move_done edge -> TIMEOUT, winner = 0, moves unchanged, further move_done ignored.
REQ-040 move_done held high 100 cycles in RUN_W -> exactly one transition, moves increments by 1. With MOVE_W = 2, 5 moves -> moves = 3.
REQ-041 With CHESS_PAUSE_EN defined, pause in RUN_B -> counts 0; move_done ignored; second pause -> RUN_B with count_b = 1. Without the macro, pause_btn has no effect.
REQ-042 reset_n pulsed low asynchronously mid-RUN_W -> all outputs take their reset values before the next clock edge.
